fetch_align_buffer: RTL and testbench
=====================================

Name: fetch_align_buffer

Overview:
- Sits between the instruction fetch interface and the control unit.
- Accepts word-aligned 32-bit fetch words and realigns them into whole instructions: 32-bit, or 16-bit RVC in the low half.
- Presents one instruction per handshake, with its PC and a compressed flag, on the `instr` input of decode.
- Handles halfword-aligned redirects, instructions that straddle word boundaries, and fetch-fault propagation.

Parameters:
- RESET_PC, 32'h8000_0000, PC of first instruction after reset.
- BUF_HW, 4, halfword slot capacity (fixed at 4; other values are not supported).

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous active-high reset
- fetch_valid  input  1  fetch word available
- fetch_ready  output  1  buffer accepts fetch word this cycle
- fetch_word  input  32  word-aligned instruction data
- fetch_fault  input  1  access fault for this fetch word
- flush  input  1  redirect; discard buffered state
- flush_pc  input  32  redirect target (bit 0 ignored)
- instr_valid  output  1  instr/pc/flags valid
- instr_ready  input  1  decode consumes instruction
- instr  output  32  instruction; compressed = {16'h0, parcel}
- instr_pc  output  32  PC of instr
- instr_compressed  output  1  instr is 16-bit RVC
- instr_fault  output  1  instruction fetch fault

Behaviour:
- **Storage:** 4 halfword slots, each {data[15:0], fault}; occupancy hw_cnt in 0..4; registers pc_q and drop_first.
- **Reset:** hw_cnt=0, pc_q=RESET_PC, drop_first=0. All outputs 0 except fetch_ready=1.
- **Fetch acceptance:**
  - fetch_ready = !flush && hw_cnt<=2.
  - On accept with drop_first=0: push low half, then high half.
  - On accept with drop_first=1: push high half only, then clear drop_first.
  - Both pushed slots carry fault=fetch_fault.
- **Compressed detection:** slot0.data[1:0] != 2'b11.
- **Output valid:** instr_valid = (hw_cnt>=1 && (compressed || slot0.fault)) || hw_cnt>=2.
- **Output fault:** instr_fault = slot0.fault, or (!compressed && slot1.fault). When asserted, instr=0.
- **Pop:** on instr_valid && instr_ready && !instr_fault, pop 1 slot (compressed) or 2 slots. pc_q += 2 or 4, with 32-bit wrap.
- **Fault hold:** a faulting instruction is held valid. Pop is ignored until flush; decode raises the exception.
- **Simultaneous pop and push:** pop is applied first, then the push appends behind the remaining slots. Net hw_cnt never exceeds 4.
- **Output stability:** outputs stay stable while instr_valid && !instr_ready.
- **Flush:**
  - Takes priority over push and pop in the same cycle.
  - Next cycle: hw_cnt=0, pc_q={flush_pc[31:1],1'b0}, drop_first=flush_pc[1].
  - Any fetch word presented during the flush cycle is not accepted.
  - The first word accepted after flush belongs to the new stream.
- **Latency:** 1 cycle from fetch accept to instr_valid (registered path).
- **Async reset mid-operation:** clears everything immediately; pending handshakes are lost.

Optional Feature:
- Macro: FETCH_ALIGN_BYPASS_EN.
- **Defined:**
  - When hw_cnt==0 and a word is accepted, instr/instr_valid are driven combinationally from fetch_word in the same cycle.
  - This applies only if the word holds a complete instruction: a compressed selected half, or a 32-bit instruction with drop_first=0.
  - If decode consumes it, nothing is stored; leftover halfwords are stored.
- **Undefined:** always registered; 1-cycle latency.

Decomposition:
- **Package fetch_align_pkg:**
  - halfword_t
  - hw_slot_t struct {data, fault}
  - constant RVC_OPC_FULL=2'b11
  - function is_compressed(halfword_t)
- **Sub-module fetch_align_queue:** 4-slot halfword shift queue with push1/push2/pop1/pop2/clear and count. The top level holds the PC, drop_first and handshake logic.

Test Plan:
- **Aligned 32-bit stream:** reset; fetch 32'h0000_0013, 32'h0010_0093 → two instrs, pc 8000_0000 then 8000_0004, compressed=0, 1-cycle latency each.
- **Mixed RVC:** word 32'h0013_4501 (low c.li a0,0; high starts a 32-bit instr), then 32'h0000_0000 → compressed 0x4501 @8000_0000, then 32-bit 32'h0000_0013 @8000_0002 straddling the boundary.
- **Halfword redirect:** flush_pc=8000_0102, word 32'h4585_0001 → single instr 0x4585, compressed, pc 8000_0102; low half discarded.
- **Backpressure:** instr_ready=0 with 4 compressed halfwords buffered → fetch_ready=0, outputs stable. Release → pc advances by 2 per cycle.
- **Fault on straddle:** 32-bit instr whose upper half comes from a word with fetch_fault=1 → instr_valid=1, instr_fault=1, instr=0, held until flush.
- **Flush vs. pop:** flush with instr_ready=1 and fetch_valid=1 in the same cycle → no pop, no push; hw_cnt=0 next cycle.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg
//   Shared types and helpers for the fetch realignment buffer.
//   halfword_t      : one 16-bit instruction parcel
//   hw_slot_t       : buffered parcel plus the fetch fault it arrived with
//   RVC_OPC_FULL    : low opcode bits marking a full 32-bit instruction
//   is_compressed() : true when a parcel starts a 16-bit RVC instruction
package fetch_align_pkg;

    typedef logic [15:0] halfword_t;

    typedef struct packed {
        halfword_t data;
        logic      fault;
    } hw_slot_t;

    localparam logic [1:0] RVC_OPC_FULL = 2'b11;

    function automatic logic is_compressed(halfword_t hw);
        return hw[1:0] != RVC_OPC_FULL;
    endfunction

endpackage

// File: rtl/fetch_align_queue.sv
// fetch_align_queue
//   Halfword shift queue. Slot 0 is the oldest parcel. A pop and a push may
//   happen in the same cycle: the pop shifts first, the push then appends
//   behind whatever remains. clear empties the queue and wins over all else.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     clear           : discard all slots
//     pop1 / pop2     : remove one / two slots from the head
//     push1 / push2   : append push_a / push_a then push_b
//     head0 / head1   : slot 0 / slot 1 (zero when unoccupied)
//     count           : number of occupied slots
module fetch_align_queue
    import fetch_align_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     pop1,
    input  logic     pop2,
    input  logic     push1,
    input  logic     push2,
    input  hw_slot_t push_a,
    input  hw_slot_t push_b,
    output hw_slot_t head0,
    output hw_slot_t head1,
    output logic [2:0] count
);

    localparam int SW = $bits(hw_slot_t);

    hw_slot_t [DEPTH-1:0] slots_q;
    hw_slot_t [DEPTH-1:0] slots_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [2:0] pop_n;
    logic [2:0] base;

    always_comb begin
        pop_n = pop2 ? 3'd2 : (pop1 ? 3'd1 : 3'd0);
        base  = cnt_q - pop_n;
        // Vacated slots shift in as zero so unoccupied heads read clean.
        slots_d = slots_q >> (SW * int'(pop_n));
        for (int i = 0; i < DEPTH; i++) begin
            if ((push1 || push2) && base == 3'(i))
                slots_d[i] = push_a;
            if (push2 && (base + 3'd1) == 3'(i))
                slots_d[i] = push_b;
        end
        cnt_d = base + (push2 ? 3'd2 : (push1 ? 3'd1 : 3'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q <= '0;
            cnt_q   <= 3'd0;
        end else if (clear) begin
            slots_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            slots_q <= slots_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head0 = slots_q[0];
    assign head1 = slots_q[1];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer
//   Realigns word-aligned 32-bit fetch words into whole RISC-V instructions
//   (32-bit, or 16-bit RVC) for decode. Handles halfword-aligned redirects,
//   instructions straddling fetch words, and fetch-fault propagation.
//   Optional macro FETCH_ALIGN_BYPASS_EN: when the buffer is empty, a complete
//   instruction in the accepted fetch word is presented combinationally in
//   the same cycle. Without it the path is registered (1-cycle latency).
//   Ports:
//     CLK, RST                      : clock, asynchronous active-high reset
//     fetch_valid/ready/word/fault  : fetch word handshake
//     flush, flush_pc               : redirect, discards buffered state
//     instr_valid/ready             : decode handshake
//     instr, instr_pc               : instruction (RVC zero-extended) and PC
//     instr_compressed, instr_fault : RVC flag, fetch fault (instr forced 0)
module fetch_align_buffer
    import fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_word,
    input  logic        fetch_fault,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed,
    output logic        instr_fault
);

    logic [31:0] pc_q;
    logic        drop_first;

    hw_slot_t    head0, head1;
    logic [2:0]  hw_cnt;
    logic        q_pop1, q_pop2, q_push1, q_push2;
    hw_slot_t    push_a, push_b;

    hw_slot_t    fetch_lo, fetch_hi;
    logic        accept;
    logic        buf_comp, buf_valid, buf_fault;
    logic        out_valid, out_comp, out_fault, bypass, take;
    halfword_t   out_lo, out_hi;

    assign fetch_lo    = '{data: fetch_word[15:0],  fault: fetch_fault};
    assign fetch_hi    = '{data: fetch_word[31:16], fault: fetch_fault};
    // At most two slots occupied guarantees room for a full word.
    assign fetch_ready = !flush && hw_cnt <= 3'd2;
    assign accept      = fetch_valid && fetch_ready;

    assign buf_comp  = is_compressed(head0.data);
    assign buf_valid = (hw_cnt >= 3'd1 && (buf_comp || head0.fault)) || hw_cnt >= 3'd2;
    assign buf_fault = head0.fault || (!buf_comp && head1.fault);

    always_comb begin
        out_valid = buf_valid;
        out_comp  = buf_comp;
        out_fault = buf_fault;
        out_lo    = head0.data;
        out_hi    = head1.data;
        bypass    = 1'b0;
`ifdef FETCH_ALIGN_BYPASS_EN
        if (hw_cnt == 3'd0 && accept) begin
            // A 32-bit instruction is only complete when the low half is used.
            if (is_compressed(drop_first ? fetch_word[31:16] : fetch_word[15:0]) || !drop_first) begin
                bypass    = 1'b1;
                out_valid = 1'b1;
                out_lo    = drop_first ? fetch_word[31:16] : fetch_word[15:0];
                out_hi    = fetch_word[31:16];
                out_comp  = is_compressed(out_lo);
                out_fault = fetch_fault;
            end
        end
`endif
    end

    // Faulting instructions never pop; they stay presented until a flush.
    assign take   = out_valid && instr_ready && !out_fault && !flush;
    assign q_pop1 = take && !bypass && out_comp;
    assign q_pop2 = take && !bypass && !out_comp;

    always_comb begin
        q_push1 = 1'b0;
        q_push2 = 1'b0;
        push_a  = fetch_lo;
        push_b  = fetch_hi;
        if (accept) begin
            if (bypass && take) begin
                // Consumed straight from the fetch word: keep only a leftover
                // high parcel behind a low-half RVC instruction.
                if (!drop_first && out_comp) begin
                    q_push1 = 1'b1;
                    push_a  = fetch_hi;
                end
            end else if (drop_first) begin
                q_push1 = 1'b1;
                push_a  = fetch_hi;
            end else begin
                q_push2 = 1'b1;
            end
        end
    end

    fetch_align_queue #(
        .DEPTH (BUF_HW)
    ) u_queue (
        .clk    (CLK),
        .rst    (RST),
        .clear  (flush),
        .pop1   (q_pop1),
        .pop2   (q_pop2),
        .push1  (q_push1),
        .push2  (q_push2),
        .push_a (push_a),
        .push_b (push_b),
        .head0  (head0),
        .head1  (head1),
        .count  (hw_cnt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q       <= RESET_PC;
            drop_first <= 1'b0;
        end else if (flush) begin
            pc_q       <= flush_pc & 32'hFFFF_FFFE;
            drop_first <= flush_pc[1];
        end else begin
            if (take)
                pc_q <= pc_q + (out_comp ? 32'd2 : 32'd4);
            if (accept)
                drop_first <= 1'b0;
        end
    end

    assign instr_valid      = out_valid;
    assign instr_fault      = out_valid && out_fault;
    assign instr_compressed = out_valid && out_comp;
    assign instr_pc         = out_valid ? pc_q : 32'h0;
    assign instr            = (out_valid && !out_fault)
                              ? (out_comp ? {16'h0, out_lo} : {out_hi, out_lo})
                              : 32'h0;

endmodule

// File: tb/tb_fetch_align_buffer.sv
module tb_fetch_align_buffer;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fetch_valid, fetch_ready, fetch_fault, flush;
    logic [31:0] fetch_word, flush_pc;
    logic        instr_valid, instr_ready, instr_compressed, instr_fault;
    logic [31:0] instr, instr_pc;

    always #5 CLK = ~CLK;

    fetch_align_buffer #(.RESET_PC(RST_PC), .BUF_HW(4)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_word       (fetch_word),
        .fetch_fault      (fetch_fault),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed),
        .instr_fault      (instr_fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue of parcels {fault, data}, a PC and a
    // pending "skip the low half" flag.
    logic [16:0] mq[$];
    logic [31:0] mpc;
    logic        mdrop;

    logic        e_valid, e_ready, e_comp, e_fault;
    logic [31:0] e_instr, e_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_expect();
        int n;
        logic c;
        n = mq.size();
        c = (n > 0) && (mq[0][1:0] != 2'b11);
        e_valid = (n >= 1 && (c || mq[0][16])) || n >= 2;
        e_fault = e_valid && (mq[0][16] || (!c && n >= 2 && mq[1][16]));
        e_comp  = e_valid && c;
        e_pc    = e_valid ? mpc : 32'h0;
        if (!e_valid || e_fault) e_instr = 32'h0;
        else if (c)              e_instr = {16'h0, mq[0][15:0]};
        else                     e_instr = {mq[1][15:0], mq[0][15:0]};
        e_ready = !flush && n <= 2;
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = RST_PC;
        mdrop = 1'b0;
    endtask

    task automatic model_clock();
        int k;
        if (flush) begin
            mq.delete();
            mpc   = {flush_pc[31:1], 1'b0};
            mdrop = flush_pc[1];
        end else begin
            if (e_valid && instr_ready && !e_fault) begin
                k = e_comp ? 1 : 2;
                repeat (k) void'(mq.pop_front());
                mpc = mpc + 32'(2 * k);
            end
            if (fetch_valid && e_ready) begin
                if (!mdrop) mq.push_back({fetch_fault, fetch_word[15:0]});
                mq.push_back({fetch_fault, fetch_word[31:16]});
                mdrop = 1'b0;
            end
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_word  = 32'h0;
        fetch_fault = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        instr_ready = 1'b0;
    endtask

    // One cycle: drive, compare DUT to model, clock, advance model, go idle.
    task automatic step(input logic fv, input logic [31:0] fw, input logic ff,
                        input logic fl, input logic [31:0] fpc, input logic ir);
        @(negedge CLK);
        fetch_valid = fv;
        fetch_word  = fw;
        fetch_fault = ff;
        flush       = fl;
        flush_pc    = fpc;
        instr_ready = ir;
        #1;
        model_expect();
        chk("fetch_ready", fetch_ready, e_ready);
        chk("instr_valid", instr_valid, e_valid);
        chk("instr", instr, e_instr);
        chk("instr_pc", instr_pc, e_pc);
        chk("instr_compressed", instr_compressed, e_comp);
        chk("instr_fault", instr_fault, e_fault);
        @(posedge CLK);
        model_clock();
        #1;
        idle();
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        model_reset();
        do_reset();

        // Reset state
        chk("rst fetch_ready", fetch_ready, 1);
        chk("rst instr_valid", instr_valid, 0);
        chk("rst instr", instr, 0);
        chk("rst instr_pc", instr_pc, 0);
        chk("rst flags", {instr_compressed, instr_fault}, 0);

        // Aligned 32-bit stream
        step(1, 32'h0000_0013, 0, 0, 0, 0);
        chk("al1 valid", instr_valid, 1);
        chk("al1 instr", instr, 32'h0000_0013);
        chk("al1 pc", instr_pc, 32'h8000_0000);
        chk("al1 comp", instr_compressed, 0);
        step(1, 32'h0010_0093, 0, 0, 0, 1);
        chk("al2 instr", instr, 32'h0010_0093);
        chk("al2 pc", instr_pc, 32'h8000_0004);
        step(0, 0, 0, 0, 0, 1);
        chk("al drained", instr_valid, 0);

        // Mixed RVC with a straddling 32-bit instruction
        do_reset();
        step(1, 32'h0013_4501, 0, 0, 0, 0);
        chk("mx1 instr", instr, 32'h0000_4501);
        chk("mx1 comp", instr_compressed, 1);
        chk("mx1 pc", instr_pc, 32'h8000_0000);
        step(1, 32'h0000_0000, 0, 0, 0, 1);
        chk("mx2 instr", instr, 32'h0000_0013);
        chk("mx2 comp", instr_compressed, 0);
        chk("mx2 pc", instr_pc, 32'h8000_0002);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Halfword redirect
        step(0, 0, 0, 1, 32'h8000_0102, 0);
        step(1, 32'h4585_0001, 0, 0, 0, 0);
        chk("rd instr", instr, 32'h0000_4585);
        chk("rd comp", instr_compressed, 1);
        chk("rd pc", instr_pc, 32'h8000_0102);
        step(0, 0, 0, 0, 0, 1);
        chk("rd single", instr_valid, 0);

        // Backpressure with four buffered RVC parcels
        step(0, 0, 0, 1, 32'h0000_1000, 0);
        step(1, 32'h0001_0001, 0, 0, 0, 0);
        step(1, 32'h0001_0001, 0, 0, 0, 0);
        chk("bp full ready", fetch_ready, 0);
        chk("bp instr", instr, 32'h0000_0001);
        step(1, 32'h0001_0001, 0, 0, 0, 0);
        chk("bp stable pc", instr_pc, 32'h0000_1000);
        chk("bp stable instr", instr, 32'h0000_0001);
        step(0, 0, 0, 0, 0, 1);
        chk("bp rel1 pc", instr_pc, 32'h0000_1002);
        step(0, 0, 0, 0, 0, 1);
        chk("bp rel2 pc", instr_pc, 32'h0000_1004);
        step(0, 0, 0, 0, 0, 1);
        chk("bp rel3 pc", instr_pc, 32'h0000_1006);
        step(0, 0, 0, 0, 0, 1);
        chk("bp empty", instr_valid, 0);

        // Fault on the upper half of a straddling instruction
        step(0, 0, 0, 1, 32'h0000_2002, 0);
        step(1, 32'h0013_ABCD, 0, 0, 0, 0);
        chk("ft partial", instr_valid, 0);
        step(1, 32'h1234_0000, 1, 0, 0, 1);
        chk("ft valid", instr_valid, 1);
        chk("ft fault", instr_fault, 1);
        chk("ft instr", instr, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("ft held", {instr_valid, instr_fault}, 2'b11);
        chk("ft held pc", instr_pc, 32'h0000_2002);

        // Flush against pop and push in the same cycle
        step(1, 32'h0000_0013, 0, 1, 32'h0000_3000, 1);
        chk("fl valid", instr_valid, 0);
        chk("fl ready", fetch_ready, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("fl no push", instr_valid, 0);
        step(1, 32'h0001_0001, 0, 0, 0, 0);
        chk("fl new pc", instr_pc, 32'h0000_3000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w, p;
            w = $urandom;
            p = $urandom;
            if ($urandom_range(0, 3) == 0) p[1] = 1'b1;
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, p, $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset mid-operation
        step(1, 32'h0000_0013, 0, 0, 0, 0);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async rst valid", instr_valid, 0);
        chk("async rst ready", fetch_ready, 1);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(1, 32'h0000_0093, 0, 0, 0, 1);
        chk("post rst pc", instr_pc, RST_PC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
